// File: rtl/gsqrt_ctrl_pkg.sv
// Shared types and constants for the gain-based unary square-root job controller:
// FSM state encoding and the maximal-length Fibonacci LFSR tap table.
package gsqrt_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WARM,
    RUN,
    DONE
  } state_t;

  // Bit i set means register bit i feeds the XOR; polynomials are primitive for widths 3..16.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] taps;
    case (width)
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/gsqrt_job_ctrl_lfsr.sv
// Maximal-length Fibonacci LFSR, shifting left with the feedback bit entering the LSB.
// Reset and load both return it to SEED; otherwise it steps only when enabled.
module lfsr_fib
  import gsqrt_ctrl_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] SEED = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  output logic [W-1:0] q
);

  localparam logic [15:0]  TAP_ALL = lfsr_taps(W);
  localparam logic [W-1:0] TAPS    = TAP_ALL[W-1:0];

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[W-2:0], ^(q & TAPS)};
    end
  end

endmodule

// File: rtl/gsqrt_job_ctrl.sv
// Job sequencer for a gain-based unary square-root datapath: clears it, streams a
// unary-encoded operand, skips a warm-up window and counts output ones over len cycles.
module gsqrt_job_ctrl
  import gsqrt_ctrl_pkg::*;
#(
  parameter int DEP     = 5,
  parameter int IWID    = 8,
  parameter int LEN_W   = 16,
  parameter int WARM_W  = 8,
  parameter int SEED_IN = 1,
  parameter int SEED_DP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [IWID-1:0]   operand,
  input  logic [LEN_W-1:0]  len,
  input  logic [WARM_W-1:0] warm,
  output logic              dp_rst_n,
  output logic              dp_in,
  output logic [DEP-1:0]    dp_rand,
  input  logic              dp_out,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [LEN_W-1:0]  result,
  output logic              busy
);

  if (SEED_IN == 0) begin : g_bad_seed_in
    $error("gsqrt_job_ctrl: SEED_IN must be nonzero");
  end
  if (SEED_DP == 0) begin : g_bad_seed_dp
    $error("gsqrt_job_ctrl: SEED_DP must be nonzero");
  end

  state_t             state;
  logic [IWID-1:0]    operand_q;
  logic [WARM_W-1:0]  warm_cnt;
  logic [LEN_W-1:0]   len_cnt;
  logic [LEN_W-1:0]   ones_cnt;
  logic [IWID-1:0]    lfsr_in;
  logic               accept;
  logic               active;
  logic [WARM_W-1:0]  warm_dec;
  logic [LEN_W-1:0]   len_dec;
  logic [LEN_W-1:0]   ones_nxt;

  assign accept   = start_valid & start_ready;
  assign active   = (state == WARM) || (state == RUN);
  assign warm_dec = warm_cnt - WARM_W'(1);
  assign len_dec  = len_cnt - LEN_W'(1);
  // Count includes this cycle's dp_out so the final RUN sample lands in result.
  assign ones_nxt = ones_cnt + LEN_W'((state == RUN) && dp_out);

  assign dp_in = active && (operand_q >= lfsr_in);

  lfsr_fib #(.W(IWID), .SEED(IWID'(SEED_IN))) u_lfsr_in (
    .clk  (clk),
    .rst  (rst),
    .en   (active),
    .load (accept),
    .q    (lfsr_in)
  );

  lfsr_fib #(.W(DEP), .SEED(DEP'(SEED_DP))) u_lfsr_dp (
    .clk  (clk),
    .rst  (rst),
    .en   (active),
    .load (accept),
    .q    (dp_rand)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      start_ready  <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      dp_rst_n     <= 1'b0;
      operand_q    <= '0;
      warm_cnt     <= '0;
      len_cnt      <= '0;
      ones_cnt     <= '0;
    end else begin
      // The only way into CLEAR is an accept, so this tracks next_state == CLEAR.
      dp_rst_n <= ~accept;
      case (state)
        IDLE: begin
          if (accept) begin
            operand_q   <= operand;
            warm_cnt    <= warm;
            len_cnt     <= len;
            ones_cnt    <= '0;
            state       <= CLEAR;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        CLEAR: begin
          if (warm_cnt != '0) begin
            state <= WARM;
          end else if (len_cnt != '0) begin
            state <= RUN;
          end else begin
            state        <= DONE;
            result_valid <= 1'b1;
            result       <= ones_cnt;
          end
        end
        WARM: begin
          warm_cnt <= warm_dec;
          if (warm_dec == '0) begin
            if (len_cnt != '0) begin
              state <= RUN;
            end else begin
              state        <= DONE;
              result_valid <= 1'b1;
              result       <= ones_cnt;
            end
          end
        end
        RUN: begin
          len_cnt  <= len_dec;
          ones_cnt <= ones_nxt;
          if (len_dec == '0) begin
            state        <= DONE;
            result_valid <= 1'b1;
            result       <= ones_nxt;
          end
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsqrt_job_ctrl.sv
// Directed self-checking bench for gsqrt_job_ctrl; outputs are sampled on the falling
// edge, and cycle 1 is the cycle after the accept edge.
module tb_gsqrt_job_ctrl;

  localparam int DEP     = 5;
  localparam int IWID    = 8;
  localparam int LEN_W   = 16;
  localparam int WARM_W  = 8;
  localparam int SEED_IN = 1;
  localparam int SEED_DP = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_valid = 1'b0;
  logic              start_ready;
  logic [IWID-1:0]   operand = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [WARM_W-1:0] warm = '0;
  logic              dp_rst_n;
  logic              dp_in;
  logic [DEP-1:0]    dp_rand;
  logic              dp_out;
  logic              result_valid;
  logic              result_ready = 1'b1;
  logic [LEN_W-1:0]  result;
  logic              busy;

  logic loop_en = 1'b0;
  logic dp_drv  = 1'b0;
  assign dp_out = loop_en ? dp_in : dp_drv;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gsqrt_job_ctrl #(
    .DEP(DEP), .IWID(IWID), .LEN_W(LEN_W), .WARM_W(WARM_W),
    .SEED_IN(SEED_IN), .SEED_DP(SEED_DP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .operand      (operand),
    .len          (len),
    .warm         (warm),
    .dp_rst_n     (dp_rst_n),
    .dp_in        (dp_in),
    .dp_rand      (dp_rand),
    .dp_out       (dp_out),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // x^5+x^3+1, shift left
  function automatic logic [4:0] dp_step(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  // x^8+x^6+x^5+x^4+1, shift left
  function automatic logic [7:0] in_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Call at a falling edge; returns at the falling edge of cycle 1.
  task automatic start_job(input logic [IWID-1:0] op, input logic [WARM_W-1:0] w,
                           input logic [LEN_W-1:0] l);
    operand     = op;
    warm        = w;
    len         = l;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] rs;
    logic [7:0] is;
    int         exp_cnt;
    int         rv_seen;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst start_ready", start_ready, 1);
    check("rst result_valid", result_valid, 0);
    check("rst result", result, 0);
    check("rst dp_rst_n", dp_rst_n, 0);
    check("rst dp_in", dp_in, 0);
    check("rst dp_rand", dp_rand, SEED_DP);
    check("rst busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle dp_rst_n", dp_rst_n, 1);

    // operand 0, warm 4, len 16, dp_out tied high
    dp_drv = 1'b1;
    start_job(8'd0, 8'd4, 16'd16);
    for (int c = 1; c <= 22; c++) begin
      check($sformatf("t1 dp_rst_n c%0d", c), dp_rst_n, (c != 1));
      if (c >= 2 && c <= 21) check($sformatf("t1 dp_in c%0d", c), dp_in, 0);
      check($sformatf("t1 result_valid c%0d", c), result_valid, (c == 22));
      if (c == 22) check("t1 result", result, 16);
      if (c < 22) @(negedge clk);
    end
    @(negedge clk);
    check("t1 back to idle", start_ready, 1);

    // operand 255, warm 3, len 100, dp_out looped from dp_in
    dp_drv  = 1'b0;
    loop_en = 1'b1;
    rs      = 5'(SEED_DP);
    start_job(8'd255, 8'd3, 16'd100);
    for (int c = 1; c <= 105; c++) begin
      check($sformatf("t2 dp_rand c%0d", c), dp_rand, rs);
      if (c >= 2 && c <= 104) begin
        check($sformatf("t2 dp_in c%0d", c), dp_in, 1);
        rs = dp_step(rs);
      end
      if (c == 104) check("t2 valid early", result_valid, 0);
      if (c == 105) begin
        check("t2 result_valid", result_valid, 1);
        check("t2 result", result, 100);
      end
      if (c < 105) @(negedge clk);
    end
    @(negedge clk);

    // operand 100, warm 0, len 30: comparator against the input LFSR sequence
    is      = 8'(SEED_IN);
    exp_cnt = 0;
    start_job(8'd100, 8'd0, 16'd30);
    for (int c = 1; c <= 32; c++) begin
      if (c >= 2 && c <= 31) begin
        check($sformatf("t3 dp_in c%0d", c), dp_in, (8'd100 >= is));
        if (8'd100 >= is) exp_cnt++;
        is = in_step(is);
      end
      if (c == 32) begin
        check("t3 result_valid", result_valid, 1);
        check("t3 result", result, exp_cnt);
      end
      if (c < 32) @(negedge clk);
    end
    @(negedge clk);

    // Zero-length jobs
    loop_en = 1'b0;
    dp_drv  = 1'b1;
    start_job(8'd50, 8'd0, 16'd0);
    check("t4a dp_rst_n c1", dp_rst_n, 0);
    check("t4a valid c1", result_valid, 0);
    check("t4a busy c1", busy, 1);
    @(negedge clk);
    check("t4a valid c2", result_valid, 1);
    check("t4a result", result, 0);
    @(negedge clk);
    start_job(8'd50, 8'd5, 16'd0);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("t4b valid c%0d", c), result_valid, (c == 7));
      if (c == 7) check("t4b result", result, 0);
      if (c < 7) @(negedge clk);
    end
    @(negedge clk);

    // Alternating dp_out, held result, ignored start
    result_ready = 1'b0;
    dp_drv       = 1'b1;
    start_job(8'd200, 8'd2, 16'd10);
    for (int c = 1; c <= 13; c++) begin
      if (c >= 4) dp_drv = ((c - 4) % 2 == 0);
      @(negedge clk);
    end
    dp_drv = 1'b0;
    for (int c = 14; c <= 23; c++) begin
      check($sformatf("t5 valid c%0d", c), result_valid, 1);
      check($sformatf("t5 result c%0d", c), result, 5);
      check($sformatf("t5 start_ready c%0d", c), start_ready, 0);
      if (c == 16) begin
        operand     = 8'd7;
        warm        = 8'd0;
        len         = 16'd3;
        start_valid = 1'b1;
      end
      if (c == 17) start_valid = 1'b0;
      if (c == 23) result_ready = 1'b1;
      @(negedge clk);
    end
    check("t5 idle start_ready", start_ready, 1);
    check("t5 idle valid", result_valid, 0);
    check("t5 idle busy", busy, 0);
    check("t5 result kept", result, 5);

    // Reset mid-RUN, then a fresh job
    dp_drv = 1'b1;
    start_job(8'd128, 8'd2, 16'd50);
    repeat (9) @(negedge clk);
    check("t6 busy in run", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 start_ready", start_ready, 1);
    check("t6 busy", busy, 0);
    check("t6 valid", result_valid, 0);
    check("t6 result", result, 0);
    check("t6 dp_rst_n", dp_rst_n, 0);
    check("t6 dp_rand", dp_rand, SEED_DP);
    rv_seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    check("t6 no result after rst", rv_seen, 0);
    loop_en = 1'b1;
    start_job(8'd255, 8'd1, 16'd8);
    repeat (9) @(negedge clk);
    check("t6 new valid c10", result_valid, 0);
    @(negedge clk);
    check("t6 new valid c11", result_valid, 1);
    check("t6 new result", result, 8);
    @(negedge clk);
    check("t6 new idle", start_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
